// File: rtl/game_pkg.sv
// Shared types and defaults for the door-game round control.
package game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} round_state_t;

  localparam int unsigned ROUND_SECS_DEF = 5;
  localparam int unsigned PAUSE_SECS_DEF = 1;
  localparam int unsigned MAX_ROUNDS_DEF = 15;
  localparam int unsigned VGA_CLK_HZ     = 25_000_000;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the pixel clock down to a one-cycle game-second tick while run is high.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TC = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;

  assign tick = run && (cnt_q == TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Round FSM: countdown, post-round pause, round counter and game-over decision.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ     = VGA_CLK_HZ,
  parameter int unsigned ROUND_SECS = ROUND_SECS_DEF,
  parameter int unsigned PAUSE_SECS = PAUSE_SECS_DEF,
  parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1_lives,
  input  logic [1:0] p2_lives,
  output logic       time_up,
  output logic       resume,
  output logic [3:0] seconds_left,
  output logic [3:0] round_num,
  output logic       game_over,
  output logic       sec_tick
);

  localparam logic [3:0] RS4 = 4'(ROUND_SECS);
  localparam logic [3:0] PS4 = 4'(PAUSE_SECS);
  localparam logic [3:0] MR4 = 4'(MAX_ROUNDS);

  round_state_t state_q;
  logic [3:0]   secs_q;
  logic [3:0]   pause_q;
  logic [3:0]   round_q;
  logic         time_up_q;
  logic         resume_q;
  logic         game_over_q;
  logic         tick;
  logic         run;
  logic         enter;

  assign run = (state_q == RUN) || (state_q == PAUSE);

  // Asserted exactly on the cycles whose edge changes state, so the prescaler restarts per state.
  always_comb begin
    enter = 1'b0;
    case (state_q)
      IDLE:    enter = start;
      RUN:     enter = tick && (secs_q == 4'd1);
      PAUSE:   enter = tick && (pause_q == 4'd1);
      default: enter = 1'b0;
    endcase
  end

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (enter),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      secs_q      <= RS4;
      pause_q     <= '0;
      round_q     <= '0;
      time_up_q   <= 1'b0;
      resume_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      resume_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            round_q <= 4'd1;
            secs_q  <= RS4;
          end
        end
        RUN: begin
          if (tick) begin
            if (secs_q == 4'd1) begin
              state_q   <= PAUSE;
              secs_q    <= '0;
              time_up_q <= 1'b1;
              pause_q   <= PS4;
            end else begin
              secs_q <= secs_q - 4'd1;
            end
          end
        end
        PAUSE: begin
          if (tick) begin
            if (pause_q == 4'd1) begin
              time_up_q <= 1'b0;
              if (p1_lives == 2'd0 || p2_lives == 2'd0) begin
                state_q     <= OVER;
                game_over_q <= 1'b1;
                secs_q      <= '0;
              end else begin
                state_q  <= RUN;
                resume_q <= 1'b1;
                secs_q   <= RS4;
                round_q  <= sat_inc(round_q, MR4);
              end
            end else begin
              pause_q <= pause_q - 4'd1;
            end
          end
        end
        OVER: begin
          state_q <= OVER;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign time_up      = time_up_q;
  assign resume       = resume_q;
  assign seconds_left = secs_q;
  assign round_num    = round_q;
  assign game_over    = game_over_q;
  assign sec_tick     = tick;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with a fast prescaler and short rounds.
module tb_round_sequencer;

  localparam int unsigned CLK = 4;
  localparam int unsigned RS  = 3;
  localparam int unsigned PS  = 1;
  localparam int unsigned MR  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic       time_up;
  logic       resume;
  logic [3:0] seconds_left;
  logic [3:0] round_num;
  logic       game_over;
  logic       sec_tick;

  typedef struct packed {
    logic       tu;
    logic       rs;
    logic       go;
    logic       tk;
    logic [3:0] secs;
    logic [3:0] rnd;
  } obs_t;

  obs_t  obs;
  obs_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  string phase = "init";

  round_sequencer #(
    .CLK_HZ    (CLK),
    .ROUND_SECS(RS),
    .PAUSE_SECS(PS),
    .MAX_ROUNDS(MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .p1_lives    (p1_lives),
    .p2_lives    (p2_lives),
    .time_up     (time_up),
    .resume      (resume),
    .seconds_left(seconds_left),
    .round_num   (round_num),
    .game_over   (game_over),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  assign obs = {time_up, resume, game_over, sec_tick, seconds_left, round_num};

  function automatic obs_t mk(input logic tu, input logic rs, input logic go,
                              input logic tk, input logic [3:0] secs, input logic [3:0] rnd);
    return {tu, rs, go, tk, secs, rnd};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, act, exp);
    end
  endtask

  task automatic step();
    obs_t e;
    @(negedge clk);
    check({phase, ".excl"}, 32'(time_up & resume), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(phase, 32'(obs), 32'(e));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_idle(input int n, input logic [3:0] rnd);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'(RS), rnd));
  endtask

  // One record per cycle after the RUN-entry edge; resume only when entered from PAUSE.
  task automatic push_round(input logic [3:0] rnd, input bit first);
    for (int k = 0; k < int'(RS * CLK); k++)
      exp_q.push_back(mk(1'b0, (!first && k == 0), 1'b0, (k % CLK == CLK - 1),
                         4'(RS - k / CLK), rnd));
  endtask

  task automatic push_pause(input int n, input logic [3:0] rnd);
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, (k % CLK == CLK - 1), 4'd0, rnd));
  endtask

  task automatic push_over(input int n, input logic [3:0] rnd);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, rnd));
  endtask

  task automatic drain_check();
    check({phase, ".drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; p1_lives = 2'd3; p2_lives = 2'd3;
    #1 reset = 1'b1;
    #1 phase = "reset";
    check(phase, 32'(obs), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'(RS), 4'd0)));
    steps(2);
    reset = 1'b0;

    phase = "idle";
    push_idle(20, 4'd0);
    steps(20);
    drain_check();

    phase = "round1";
    push_round(4'd1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(int'(RS * CLK) - 1);
    phase = "pause1";
    push_pause(int'(PS * CLK), 4'd1);
    steps(int'(PS * CLK));
    drain_check();

    phase = "round2";
    push_round(4'd2, 1'b0);
    steps(int'(RS * CLK));
    phase = "pause2";
    push_pause(int'(PS * CLK), 4'd2);
    steps(int'(PS * CLK));

    phase = "round3sat";
    push_round(4'(MR), 1'b0);
    steps(int'(RS * CLK));
    drain_check();

    phase = "pause3";
    push_pause(int'(PS * CLK), 4'(MR));
    step();
    p2_lives = 2'd0;
    push_over(50, 4'(MR));
    steps(int'(PS * CLK) - 1);
    phase = "over";
    for (int i = 0; i < 50; i++) begin
      step();
      start = (i % 10 == 3);
    end
    start = 1'b0;
    drain_check();

    phase = "reset2";
    reset = 1'b1;
    p2_lives = 2'd3;
    push_idle(3, 4'd0);
    steps(3);
    reset = 1'b0;

    phase = "round4";
    push_round(4'd1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(int'(RS * CLK) - 1);
    phase = "pause4";
    push_pause(2, 4'd1);
    steps(2);
    drain_check();
    #2 reset = 1'b1;
    #1 phase = "rst_async";
    check(phase, 32'(obs), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'(RS), 4'd0)));
    phase = "rst_hold";
    push_idle(4, 4'd0);
    steps(4);
    reset = 1'b0;
    phase = "post_rst";
    push_idle(10, 4'd0);
    steps(10);
    drain_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
